// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: round-robin sharing of one DMA read channel among NUM_REQ requesters.
module dma_rd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 42,
  parameter int SIZE_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  localparam int OW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_go,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0] req_size,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_done,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  output logic [NUM_REQ-1:0]            req_empty,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          dma_rd_go,
  output logic [ADDR_WIDTH-1:0]         dma_rd_addr,
  output logic [SIZE_WIDTH-1:0]         dma_rd_size,
  input  logic                          dma_rd_done,
  input  logic                          dma_empty,
  output logic                          dma_rd_en,
  input  logic [DATA_WIDTH-1:0]         dma_rd_data,
  output logic                          busy,
  output logic [OW-1:0]                 owner
);
  typedef enum logic [2:0] {IDLE, ISSUE, ACTIVE_WAIT, ACTIVE, DONE} state_t;
  state_t state;
  logic [OW-1:0] rr_ptr, pick;
  logic found;
  int j;
  logic [NUM_REQ-1:0] pick_hot, own_hot;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [SIZE_WIDTH-1:0] sel_size;
  logic routing;
  // Descending scan so the lowest offset from rr_ptr wins without a break.
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (req_go[j]) begin
        found = 1'b1;
        pick = OW'(j);
      end
    end
  end
  assign pick_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  assign own_hot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign sel_addr = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_size = req_size[int'(pick)*SIZE_WIDTH +: SIZE_WIDTH];
  assign routing  = state == ACTIVE || state == ACTIVE_WAIT;
  assign rd_data  = dma_rd_data;
  always_comb begin
    req_empty = '1;
    req_empty[owner] = routing ? dma_empty : 1'b1;
    dma_rd_en = routing & req_rd_en[owner] & ~dma_empty;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      req_grant <= '0;
      req_done <= '0;
      dma_rd_go <= 1'b0;
      dma_rd_addr <= '0;
      dma_rd_size <= '0;
      busy <= 1'b0;
    end else begin
      req_grant <= '0;
      req_done <= '0;
      dma_rd_go <= 1'b0;
      case (state)
        IDLE: if (found) begin
          owner <= pick;
          dma_rd_addr <= sel_addr;
          dma_rd_size <= sel_size;
          req_grant <= pick_hot;
          busy <= 1'b1;
          // Zero-length transfers complete without touching the DMA channel.
          if (sel_size == '0) begin
            req_done <= pick_hot;
            state <= DONE;
          end else begin
            dma_rd_go <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: state <= ACTIVE_WAIT;
        ACTIVE_WAIT: state <= ACTIVE;
        ACTIVE: if (dma_rd_done) begin
          req_done <= own_hot;
          state <= DONE;
        end
        DONE: begin
          rr_ptr <= owner == OW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_rd_arbiter.sv
// tb_dma_rd_arbiter: directed checks of arbitration, routing, zero-size, stale done and reset.
module tb_dma_rd_arbiter;
  localparam int NR = 2, AW = 42, SW = 32, DW = 512;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] req_go = '0, req_grant, req_done, req_rd_en = '0, req_empty;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*SW-1:0] req_size = '0;
  logic [DW-1:0] rd_data, dma_rd_data = '0;
  logic dma_rd_go, dma_rd_done = 1'b0, dma_empty = 1'b1, dma_rd_en, busy;
  logic [AW-1:0] dma_rd_addr;
  logic [SW-1:0] dma_rd_size;
  logic [0:0] owner;
  int checks = 0, errors = 0;

  dma_rd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_go(req_go), .req_addr(req_addr), .req_size(req_size),
    .req_grant(req_grant), .req_done(req_done), .req_rd_en(req_rd_en), .req_empty(req_empty),
    .rd_data(rd_data), .dma_rd_go(dma_rd_go), .dma_rd_addr(dma_rd_addr), .dma_rd_size(dma_rd_size),
    .dma_rd_done(dma_rd_done), .dma_empty(dma_empty), .dma_rd_en(dma_rd_en),
    .dma_rd_data(dma_rd_data), .busy(busy), .owner(owner));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_xfer(input int r, input logic [AW-1:0] addr, input logic [SW-1:0] size,
                         input int lines, input bit hold, input bit noise, input bit stale);
    logic [NR-1:0] hot;
    logic [DW-1:0] pat;
    hot = 2'b01 << r;
    req_addr[r*AW +: AW] = addr;
    req_size[r*SW +: SW] = size;
    tick;
    checks++;
    if (req_grant !== hot || dma_rd_go !== 1'b1) begin
      errors++;
      $display("FAIL grant r=%0d: grant=%b go=%b, want %b/1", r, req_grant, dma_rd_go, hot);
    end
    checks++;
    if (dma_rd_addr !== addr || dma_rd_size !== size) begin
      errors++;
      $display("FAIL dma_cmd r=%0d: addr=%h size=%0d, want %h/%0d", r, dma_rd_addr, dma_rd_size, addr, size);
    end
    checks++;
    if (owner !== 1'(r) || busy !== 1'b1) begin
      errors++;
      $display("FAIL owner r=%0d: owner=%0d busy=%b, want %0d/1", r, owner, busy, r);
    end
    if (!hold) req_go[r] = 1'b0;
    dma_empty = 1'b0;
    req_rd_en = noise ? 2'b11 : hot;
    #1;
    checks++;
    if (dma_rd_en !== 1'b0 || req_empty !== 2'b11) begin
      errors++;
      $display("FAIL issue_gate r=%0d: rd_en=%b empty=%b, want 0/11", r, dma_rd_en, req_empty);
    end
    tick;
    for (int i = 0; i < lines; i++) begin
      pat = {16{32'(i * 7 + r * 256 + 1)}};
      dma_rd_data = pat;
      dma_empty = 1'b0;
      req_rd_en = noise ? 2'b11 : hot;
      dma_rd_done = stale && i == 0;
      #1;
      checks++;
      if (dma_rd_en !== 1'b1 || req_empty !== ~hot) begin
        errors++;
        $display("FAIL pop r=%0d line=%0d: rd_en=%b empty=%b, want 1/%b", r, i, dma_rd_en, req_empty, ~hot);
      end
      checks++;
      if (rd_data !== pat || req_grant !== 2'b00 || dma_rd_go !== 1'b0 || req_done !== 2'b00) begin
        errors++;
        $display("FAIL active r=%0d line=%0d: data_ok=%b grant=%b go=%b done=%b, want 1/00/0/00",
                 r, i, rd_data === pat, req_grant, dma_rd_go, req_done);
      end
      tick;
    end
    dma_empty = 1'b1;
    dma_rd_done = 1'b0;
    #1;
    checks++;
    if (dma_rd_en !== 1'b0 || req_empty !== 2'b11 || req_done !== 2'b00) begin
      errors++;
      $display("FAIL empty_gate r=%0d: rd_en=%b empty=%b done=%b, want 0/11/00", r, dma_rd_en, req_empty, req_done);
    end
    dma_rd_done = 1'b1;
    tick;
    dma_rd_done = 1'b0;
    req_rd_en = '0;
    checks++;
    if (req_done !== hot || owner !== 1'(r) || busy !== 1'b1 || dma_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL done r=%0d: done=%b owner=%0d busy=%b rd_en=%b, want %b/%0d/1/0",
               r, req_done, owner, busy, dma_rd_en, hot, r);
    end
    tick;
    checks++;
    if (req_done !== 2'b00 || req_grant !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle r=%0d: done=%b grant=%b busy=%b, want 00/00/0", r, req_done, req_grant, busy);
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if (req_grant !== 2'b00 || req_done !== 2'b00 || dma_rd_go !== 1'b0 || busy !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: grant=%b done=%b go=%b busy=%b owner=%0d, want all 0",
               req_grant, req_done, dma_rd_go, busy, owner);
    end
    checks++;
    if (dma_rd_addr !== '0 || dma_rd_size !== '0 || req_empty !== 2'b11 || dma_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_dat: addr=%h size=%0d empty=%b rd_en=%b, want 0/0/11/0",
               dma_rd_addr, dma_rd_size, req_empty, dma_rd_en);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (req_grant !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: grant=%b busy=%b, want 00/0", req_grant, busy);
    end
  endtask

  task automatic test_single;
    req_go = 2'b01;
    do_xfer(0, 42'h100, 32'd4, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_size;
    req_addr[AW +: AW] = 42'h55;
    req_size[SW +: SW] = '0;
    req_go = 2'b10;
    tick;
    checks++;
    if (req_grant !== 2'b10 || req_done !== 2'b10 || dma_rd_go !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: grant=%b done=%b go=%b, want 10/10/0", req_grant, req_done, dma_rd_go);
    end
    checks++;
    if (owner !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_owner: owner=%0d busy=%b, want 1/1", owner, busy);
    end
    req_go = '0;
    req_rd_en = 2'b11;
    dma_empty = 1'b0;
    #1;
    checks++;
    if (dma_rd_en !== 1'b0 || req_empty !== 2'b11) begin
      errors++;
      $display("FAIL zero_gate: rd_en=%b empty=%b, want 0/11", dma_rd_en, req_empty);
    end
    tick;
    checks++;
    if (req_grant !== 2'b00 || req_done !== 2'b00 || dma_rd_go !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_end: grant=%b done=%b go=%b busy=%b, want 00/00/0/0", req_grant, req_done, dma_rd_go, busy);
    end
    req_rd_en = '0;
    dma_empty = 1'b1;
  endtask

  task automatic test_fairness;
    req_go = 2'b11;
    do_xfer(0, 42'h1000, 32'd2, 2, 1'b1, 1'b0, 1'b0);
    do_xfer(1, 42'h1800, 32'd2, 2, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 42'h1040, 32'd2, 2, 1'b1, 1'b0, 1'b0);
    do_xfer(1, 42'h1840, 32'd2, 2, 1'b1, 1'b0, 1'b0);
    req_go = '0;
  endtask

  task automatic test_isolation;
    req_go = 2'b01;
    do_xfer(0, 42'h2000, 32'd3, 3, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_stale_done;
    req_go = 2'b10;
    do_xfer(1, 42'h3000, 32'd2, 2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    req_go = 2'b01;
    req_addr[0 +: AW] = 42'h4000;
    req_size[0 +: SW] = 32'd3;
    tick;
    checks++;
    if (req_grant !== 2'b01) begin
      errors++;
      $display("FAIL mid_grant: grant=%b, want 01", req_grant);
    end
    req_go = '0;
    tick;
    dma_empty = 1'b0;
    req_rd_en = 2'b01;
    #1;
    checks++;
    if (dma_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_pop: rd_en=%b, want 1", dma_rd_en);
    end
    tick;
    rst = 1'b1;
    #1;
    checks++;
    if (req_grant !== 2'b00 || req_done !== 2'b00 || dma_rd_go !== 1'b0 || busy !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ctl: grant=%b done=%b go=%b busy=%b owner=%0d, want all 0",
               req_grant, req_done, dma_rd_go, busy, owner);
    end
    checks++;
    if (dma_rd_addr !== '0 || dma_rd_size !== '0 || dma_rd_en !== 1'b0 || req_empty !== 2'b11) begin
      errors++;
      $display("FAIL mid_rst_dat: addr=%h size=%0d rd_en=%b empty=%b, want 0/0/0/11",
               dma_rd_addr, dma_rd_size, dma_rd_en, req_empty);
    end
    tick;
    rst = 1'b0;
    dma_empty = 1'b1;
    req_rd_en = '0;
    req_go = 2'b10;
    do_xfer(1, 42'h7C0, 32'd2, 2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_zero_size;
    test_fairness;
    test_isolation;
    test_stale_done;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
